i2c_write_master: RTL and testbench
===================================

Name: i2c_write_master

Overview:
Parametrised I2C write-only master that serialises a multi-byte command (device address plus register/data bytes) onto an open-drain SDA/SCL pair. It is the successor to the codec configuration interface and adds several capabilities:
- configurable byte count;
- an internal SCL divider, so it runs from the system clock rather than a pre-divided clock;
- true open-drain SDA;
- per-byte ACK checking;
- automatic retry on NACK.

It sits between the codec/sensor configuration sequencer (command ROM walker) and the board I2C pins.

Parameters:
NUM_BYTES, 3, bytes per transaction including the address byte (WM8731 codec: addr + 2 data bytes); legal range 1..8.
CLK_DIV, 250, system-clock cycles per SCL quarter-period; legal minimum 2.
MAX_RETRY, 2, extra attempts after a NACK before the transaction is reported failed; legal range 0..7.

Ports:
CLK  input  1  system clock; all logic on its rising edge.
RESET  input  1  asynchronous, active-high reset.
START  input  1  request pulse; accepted only when BUSY=0.
DATA  input  8*NUM_BYTES  transaction bytes; byte 0 = DATA[8*NUM_BYTES-1 -: 8], sent first, MSB first.
BUSY  output  1  high from the cycle after START is accepted until DONE.
DONE  output  1  one-cycle pulse at transaction end (success or failure).
NACK_ERR  output  1  sticky failure flag; set with DONE when all attempts NACKed; cleared on the next accepted START.
ACK_LOG  output  NUM_BYTES  bit i=1 if byte i was ACKed in the most recent attempt; cleared at each attempt start.
RETRY_CNT  output  3  retries consumed in the current/last transaction.
I2C_SCLK  output  1  SCL; driven push-pull.
I2C_SDAT  inout  1  SDA; drives 0 or z only, never 1.

Behaviour:
- Reset (async, immediate, also mid-transaction):
  - State goes to IDLE; quarter counter, bit and byte counters go to 0.
  - BUSY=0, DONE=0, NACK_ERR=0, ACK_LOG=0, RETRY_CNT=0.
  - I2C_SCLK=1 and I2C_SDAT=z. No STOP is generated.
- Acceptance:
  - START=1 with BUSY=0 latches DATA into a shift register, clears NACK_ERR/ACK_LOG/RETRY_CNT and zeroes the quarter counter.
  - BUSY rises the next cycle.
  - START while BUSY=1 is ignored; DATA changes after acceptance have no effect.
- Timing base:
  - The quarter counter counts 0..CLK_DIV-1; a quarter ends at count CLK_DIV-1.
  - Every bus slot is 4 quarters, q0..q3.
- States: IDLE -> STRT -> BITS -> ACKS -> (BITS | STOP) -> (STRT on retry | FIN) -> IDLE.
  - STRT slot: SCL 1,1,1,0; SDA z,z,0,0. SDA falls while SCL is high.
  - BITS slot:
    - SCL 0,1,1,0 across q0..q3.
    - SDA is set to the current bit at q0 start and held through q3.
    - 8 slots per byte.
  - ACKS slot:
    - Same SCL pattern as BITS, with SDA released (z).
    - I2C_SDAT is sampled on the last cycle of q2: 0 = ACK, sets ACK_LOG[byte]; anything else = NACK.
    - On ACK with more bytes remaining -> BITS for the next byte.
    - On ACK after the last byte, or on any NACK -> STOP.
  - STOP slot: SCL 0,1,1,1; SDA 0,0,z,z. SDA rises while SCL is high.
  - After STOP:
    - On NACK with RETRY_CNT<MAX_RETRY: RETRY_CNT+1, reload the shift register from the latched copy, clear ACK_LOG, go to STRT. There is no idle gap beyond the STOP slot.
    - On NACK with retries exhausted: NACK_ERR=1.
    - Either way, after the last permitted attempt -> FIN.
  - FIN: DONE=1 for one cycle and BUSY=0 in that same cycle, then IDLE.
- Slot and cycle count per successful attempt: 1 + 9*NUM_BYTES + 1 slots, i.e. (9*NUM_BYTES+2)*4*CLK_DIV cycles. DONE asserts the cycle after the final quarter ends.
- Idle bus: SCL=1, SDA=z.
- An address-byte NACK aborts remaining bytes in that attempt; no further data bits are sent.

Test Plan:
- NUM_BYTES=3, CLK_DIV=4, slave ACKs all; START with DATA=0x34_1E_00 -> SDA shows START, bits 00110100 z 00011110 z 00000000 z, STOP; DONE exactly 464 cycles after the START cycle; ACK_LOG=3'b111, NACK_ERR=0, RETRY_CNT=0.
- Slave NACKs the address on every attempt, MAX_RETRY=2 -> three START/addr/STOP sequences, each 11 slots (176 cycles at CLK_DIV=4); DONE with NACK_ERR=1, RETRY_CNT=2, ACK_LOG=0.
- Slave NACKs byte 2 on the first attempt only -> first attempt stops after byte 2's ACK slot; the second attempt succeeds; DONE with NACK_ERR=0, RETRY_CNT=1, ACK_LOG=3'b111.
- START pulsed again mid-transaction with a different DATA -> ignored; the bus shows the original bytes only; a single DONE.
- RESET asserted during byte 1, bit 4 -> same cycle: SCL=1, SDA=z, BUSY=0; a new START afterwards runs a full clean transaction.
- Protocol checker throughout all tests -> SDA never changes while SCL=1 except START/STOP edges; SDA never driven to 1; each data bit is stable for the whole SCL-high window.

Source files
------------

// File: rtl/i2c_write_master.sv
// I2C write-only master: serialises NUM_BYTES bytes (address first, MSB first)
// onto an open-drain SDA with a push-pull SCL, checks every ACK and retries
// the whole transaction after a NACK up to MAX_RETRY times.
module i2c_write_master #(
  parameter int unsigned NUM_BYTES = 3,
  parameter int unsigned CLK_DIV   = 250,
  parameter int unsigned MAX_RETRY = 2
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   START,
  input  logic [8*NUM_BYTES-1:0] DATA,
  output logic                   BUSY,
  output logic                   DONE,
  output logic                   NACK_ERR,
  output logic [NUM_BYTES-1:0]   ACK_LOG,
  output logic [2:0]             RETRY_CNT,
  output logic                   I2C_SCLK,
  inout  wire                    I2C_SDAT
);

  localparam int unsigned DW = 8 * NUM_BYTES;
  localparam int unsigned QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  localparam logic [QW-1:0] Q_LAST    = QW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BYTE_LAST = BW'(NUM_BYTES - 1);
  localparam logic [2:0]    RETRY_MAX = 3'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STRT,
    S_BITS,
    S_ACKS,
    S_STOP,
    S_FIN
  } state_t;

  state_t         state, state_nx;
  logic [QW-1:0]  qcnt, qcnt_nx;
  logic [1:0]     quarter, quarter_nx;
  logic [2:0]     bit_cnt, bit_cnt_nx;
  logic [BW-1:0]  byte_cnt, byte_cnt_nx;
  logic [DW-1:0]  shreg, shreg_nx;
  logic [DW-1:0]  latched, latched_nx;
  logic           ack_ok, ack_ok_nx;
  logic [NUM_BYTES-1:0] ack_log_nx;
  logic [2:0]     retry_nx;
  logic           busy_nx, done_nx, nack_err_nx;
  logic           scl_nx;
  logic           sda_low, sda_low_nx;

  logic           quarter_end;
  logic           slot_end;
  logic           in_txn;

  // SDA is only ever pulled low or released; the board pull-up makes the 1
  assign I2C_SDAT = sda_low ? 1'b0 : 1'bz;

  assign quarter_end = (qcnt == Q_LAST);
  assign slot_end    = quarter_end && (quarter == 2'd3);
  assign in_txn      = (state == S_STRT) || (state == S_BITS) ||
                       (state == S_ACKS) || (state == S_STOP);

  // State and datapath registers; bus pins reset to the idle level immediately
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= S_IDLE;
      qcnt      <= '0;
      quarter   <= '0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      shreg     <= '0;
      latched   <= '0;
      ack_ok    <= 1'b0;
      ACK_LOG   <= '0;
      RETRY_CNT <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      NACK_ERR  <= 1'b0;
      I2C_SCLK  <= 1'b1;
      sda_low   <= 1'b0;
    end else begin
      state     <= state_nx;
      qcnt      <= qcnt_nx;
      quarter   <= quarter_nx;
      bit_cnt   <= bit_cnt_nx;
      byte_cnt  <= byte_cnt_nx;
      shreg     <= shreg_nx;
      latched   <= latched_nx;
      ack_ok    <= ack_ok_nx;
      ACK_LOG   <= ack_log_nx;
      RETRY_CNT <= retry_nx;
      BUSY      <= busy_nx;
      DONE      <= done_nx;
      NACK_ERR  <= nack_err_nx;
      I2C_SCLK  <= scl_nx;
      sda_low   <= sda_low_nx;
    end
  end

  // Next-state, counters and transaction bookkeeping
  always_comb begin
    state_nx    = state;
    qcnt_nx     = qcnt;
    quarter_nx  = quarter;
    bit_cnt_nx  = bit_cnt;
    byte_cnt_nx = byte_cnt;
    shreg_nx    = shreg;
    latched_nx  = latched;
    ack_ok_nx   = ack_ok;
    ack_log_nx  = ACK_LOG;
    retry_nx    = RETRY_CNT;
    nack_err_nx = NACK_ERR;

    // quarter timing runs only while a slot is on the bus
    if (in_txn) begin
      qcnt_nx = quarter_end ? '0 : qcnt + QW'(1);
      if (quarter_end) begin
        quarter_nx = quarter + 2'd1;
      end
    end

    case (state)
      S_IDLE, S_FIN: begin
        state_nx = S_IDLE;
        if (START) begin
          state_nx    = S_STRT;
          latched_nx  = DATA;
          shreg_nx    = DATA;
          ack_log_nx  = '0;
          retry_nx    = '0;
          nack_err_nx = 1'b0;
          ack_ok_nx   = 1'b0;
          qcnt_nx     = '0;
          quarter_nx  = '0;
          bit_cnt_nx  = '0;
          byte_cnt_nx = '0;
        end
      end

      S_STRT: begin
        if (slot_end) begin
          state_nx   = S_BITS;
          bit_cnt_nx = '0;
        end
      end

      S_BITS: begin
        if (slot_end) begin
          shreg_nx = {shreg[DW-2:0], 1'b0};
          if (bit_cnt == 3'd7) begin
            state_nx   = S_ACKS;
            bit_cnt_nx = '0;
          end else begin
            bit_cnt_nx = bit_cnt + 3'd1;
          end
        end
      end

      S_ACKS: begin
        // sample the slave response at the end of the SCL-high window
        if ((quarter == 2'd2) && quarter_end) begin
          ack_ok_nx = (I2C_SDAT == 1'b0);
          if (I2C_SDAT == 1'b0) begin
            ack_log_nx[byte_cnt] = 1'b1;
          end
        end
        if (slot_end) begin
          if (ack_ok && (byte_cnt != BYTE_LAST)) begin
            state_nx    = S_BITS;
            byte_cnt_nx = byte_cnt + BW'(1);
            bit_cnt_nx  = '0;
          end else begin
            state_nx = S_STOP;
          end
        end
      end

      S_STOP: begin
        if (slot_end) begin
          if (!ack_ok && (RETRY_CNT < RETRY_MAX)) begin
            // restart straight after the STOP with the original bytes
            state_nx    = S_STRT;
            retry_nx    = RETRY_CNT + 3'd1;
            shreg_nx    = latched;
            ack_log_nx  = '0;
            byte_cnt_nx = '0;
            bit_cnt_nx  = '0;
          end else begin
            state_nx = S_FIN;
            if (!ack_ok) begin
              nack_err_nx = 1'b1;
            end
          end
        end
      end

      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Registered status and bus levels, decoded from the upcoming state
  always_comb begin
    busy_nx    = 1'b0;
    done_nx    = 1'b0;
    scl_nx     = 1'b1;
    sda_low_nx = 1'b0;

    busy_nx = (state_nx != S_IDLE) && (state_nx != S_FIN);
    done_nx = (state_nx == S_FIN);

    case (state_nx)
      S_STRT: begin
        scl_nx     = (quarter_nx != 2'd3);
        sda_low_nx = quarter_nx[1];
      end
      S_BITS: begin
        scl_nx     = (quarter_nx == 2'd1) || (quarter_nx == 2'd2);
        sda_low_nx = !shreg_nx[DW-1];
      end
      S_ACKS: begin
        scl_nx     = (quarter_nx == 2'd1) || (quarter_nx == 2'd2);
        sda_low_nx = 1'b0;
      end
      S_STOP: begin
        scl_nx     = (quarter_nx != 2'd0);
        sda_low_nx = !quarter_nx[1];
      end
      default: begin
        scl_nx     = 1'b1;
        sda_low_nx = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_i2c_write_master.sv
// Directed bench for i2c_write_master: bus monitor + ACK/NACK slave model.
module tb_i2c_write_master;

  localparam int unsigned NB = 3;
  localparam int unsigned CD = 4;
  localparam int unsigned MR = 2;
  localparam int unsigned TXN_CYC = (9 * NB + 2) * 4 * CD;  // 464

  logic            CLK = 1'b0;
  logic            RESET = 1'b1;
  logic            START = 1'b0;
  logic [8*NB-1:0] DATA = '0;
  logic            BUSY, DONE, NACK_ERR;
  logic [NB-1:0]   ACK_LOG;
  logic [2:0]      RETRY_CNT;
  logic            I2C_SCLK;
  wire             sda;
  logic            sda_line;

  logic  slave_low = 1'b0;
  int    checks = 0;
  int    errors = 0;

  // slave configuration, written by the stimulus only
  int    nack_byte = -1;
  int    nack_att = 0;
  int    clr_req = 0;

  // monitor / slave state, written by the monitor only
  int    clr_ack = 0;
  string mon_log = "";
  int    attempt = 0;
  int    bitn = 0;
  int    byte_idx = 0;
  logic  prev_scl = 1'b1;
  logic  prev_sda = 1'b1;
  logic  pend = 1'b0;
  logic  pend_valid = 1'b0;

  pullup (sda);
  assign sda = slave_low ? 1'b0 : 1'bz;
  assign sda_line = (sda === 1'b0) ? 1'b0 : 1'b1;

  i2c_write_master #(.NUM_BYTES(NB), .CLK_DIV(CD), .MAX_RETRY(MR)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .DATA(DATA),
    .BUSY(BUSY), .DONE(DONE), .NACK_ERR(NACK_ERR), .ACK_LOG(ACK_LOG),
    .RETRY_CNT(RETRY_CNT), .I2C_SCLK(I2C_SCLK), .I2C_SDAT(sda)
  );

  always #5 CLK = ~CLK;

  // Bus monitor: logs S/P conditions and bits committed on SCL fall; acts as slave
  always @(posedge CLK) begin
    #2;
    if (clr_req != clr_ack) begin
      clr_ack = clr_req;
      mon_log = "";
      attempt = 0;
      bitn = 0;
      byte_idx = 0;
      slave_low = 1'b0;
      pend_valid = 1'b0;
    end
    if (prev_scl && I2C_SCLK && (sda_line != prev_sda)) begin
      pend_valid = 1'b0;
      if (!sda_line) begin
        mon_log = {mon_log, "S"};
        attempt++;
        bitn = 0;
        byte_idx = 0;
        slave_low = 1'b0;
      end else begin
        mon_log = {mon_log, "P"};
      end
    end else if (!prev_scl && I2C_SCLK) begin
      pend = sda_line;
      pend_valid = 1'b1;
    end else if (prev_scl && !I2C_SCLK && pend_valid) begin
      pend_valid = 1'b0;
      mon_log = $sformatf("%s%0d", mon_log, pend);
      bitn++;
      if (bitn == 8) begin
        slave_low = !((byte_idx == nack_byte) && (attempt <= nack_att));
      end else if (bitn == 9) begin
        slave_low = 1'b0;
        bitn = 0;
        byte_idx++;
      end
    end
    prev_scl = I2C_SCLK;
    prev_sda = sda_line;
  end

  // Expected bus trace for one attempt; nb = byte index the slave NACKs (-1 none)
  function automatic string exp_attempt(input logic [8*NB-1:0] d, input int nb);
    string s;
    s = "S";
    for (int b = 0; b < NB; b++) begin
      for (int i = 7; i >= 0; i--) begin
        s = $sformatf("%s%0d", s, d[8*(NB-1-b)+i]);
      end
      if (b == nb) begin
        s = {s, "1P"};
        return s;
      end
      s = {s, "0"};
    end
    s = {s, "P"};
    return s;
  endfunction

  task automatic prep(input int nb, input int na);
    nack_byte = nb;
    nack_att = na;
    clr_req++;
    @(posedge CLK);
    #3;
  endtask

  // Pulse START for one edge and check the acceptance side effects
  task automatic start_txn(input logic [8*NB-1:0] d);
    @(negedge CLK);
    DATA = d;
    START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    checks++;
    if (BUSY !== 1'b1) begin errors++; $display("FAIL accept_busy: got %b expected 1", BUSY); end
    checks++;
    if (NACK_ERR !== 1'b0 || RETRY_CNT !== 3'd0 || ACK_LOG !== '0) begin
      errors++;
      $display("FAIL accept_clear: nack_err=%b retry=%0d ack_log=%b expected 0/0/0", NACK_ERR, RETRY_CNT, ACK_LOG);
    end
  endtask

  // Count cycles from the accepting edge until DONE, with a bound
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (DONE !== 1'b1 && cyc < 3000) begin
      @(posedge CLK);
      #1;
      cyc++;
    end
    checks++;
    if (DONE !== 1'b1) begin errors++; $display("FAIL done_timeout: no DONE after %0d cycles", cyc); end
    checks++;
    if (BUSY !== 1'b0) begin errors++; $display("FAIL done_busy: got %b expected 0", BUSY); end
    @(posedge CLK);
    #1;
    checks++;
    if (DONE !== 1'b0) begin errors++; $display("FAIL done_pulse: got %b expected 0", DONE); end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (BUSY !== 1'b0 || DONE !== 1'b0 || NACK_ERR !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: busy=%b done=%b nack_err=%b expected 0", BUSY, DONE, NACK_ERR);
    end
    checks++;
    if (ACK_LOG !== '0 || RETRY_CNT !== 3'd0) begin
      errors++;
      $display("FAIL reset_counts: ack_log=%b retry=%0d expected 0", ACK_LOG, RETRY_CNT);
    end
    checks++;
    if (I2C_SCLK !== 1'b1 || sda_line !== 1'b1) begin
      errors++;
      $display("FAIL reset_bus: scl=%b sda=%b expected 1/1", I2C_SCLK, sda_line);
    end
    @(negedge CLK);
    RESET = 1'b0;
    repeat (3) @(posedge CLK);
  endtask

  task automatic test_basic();
    int cyc;
    string e;
    prep(-1, 0);
    start_txn(24'h341E00);
    wait_done(cyc);
    e = exp_attempt(24'h341E00, -1);
    checks++;
    if (cyc != TXN_CYC) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", cyc, TXN_CYC); end
    checks++;
    if (mon_log != e) begin errors++; $display("FAIL basic_bus: got %s expected %s", mon_log, e); end
    checks++;
    if (ACK_LOG !== 3'b111 || NACK_ERR !== 1'b0 || RETRY_CNT !== 3'd0) begin
      errors++;
      $display("FAIL basic_status: ack_log=%b nack_err=%b retry=%0d expected 111/0/0", ACK_LOG, NACK_ERR, RETRY_CNT);
    end
    checks++;
    if (I2C_SCLK !== 1'b1 || sda_line !== 1'b1) begin
      errors++;
      $display("FAIL basic_idle: scl=%b sda=%b expected 1/1", I2C_SCLK, sda_line);
    end
  endtask

  task automatic test_addr_nack();
    int cyc;
    string e;
    prep(0, 99);
    start_txn(24'h341E00);
    wait_done(cyc);
    e = exp_attempt(24'h341E00, 0);
    e = {e, e, e};
    checks++;
    if (cyc != 3 * 11 * 4 * CD) begin errors++; $display("FAIL addr_latency: got %0d expected %0d", cyc, 3 * 11 * 4 * CD); end
    checks++;
    if (mon_log != e) begin errors++; $display("FAIL addr_bus: got %s expected %s", mon_log, e); end
    checks++;
    if (NACK_ERR !== 1'b1 || RETRY_CNT !== 3'd2 || ACK_LOG !== 3'b000) begin
      errors++;
      $display("FAIL addr_status: nack_err=%b retry=%0d ack_log=%b expected 1/2/000", NACK_ERR, RETRY_CNT, ACK_LOG);
    end
  endtask

  task automatic test_retry_byte2();
    int cyc;
    string e;
    prep(2, 1);
    start_txn(24'h1A2B3C);
    wait_done(cyc);
    e = {exp_attempt(24'h1A2B3C, 2), exp_attempt(24'h1A2B3C, -1)};
    checks++;
    if (cyc != 2 * TXN_CYC) begin errors++; $display("FAIL retry_latency: got %0d expected %0d", cyc, 2 * TXN_CYC); end
    checks++;
    if (mon_log != e) begin errors++; $display("FAIL retry_bus: got %s expected %s", mon_log, e); end
    checks++;
    if (NACK_ERR !== 1'b0 || RETRY_CNT !== 3'd1 || ACK_LOG !== 3'b111) begin
      errors++;
      $display("FAIL retry_status: nack_err=%b retry=%0d ack_log=%b expected 0/1/111", NACK_ERR, RETRY_CNT, ACK_LOG);
    end
  endtask

  task automatic test_back_to_back();
    int done_cnt;
    int first_done;
    string e;
    prep(-1, 0);
    start_txn(24'hA055C3);
    done_cnt = 0;
    first_done = 0;
    for (int c = 1; c <= TXN_CYC + 60; c++) begin
      @(posedge CLK);
      #1;
      if (c == 100) begin
        START = 1'b1;
        DATA = 24'h123456;
      end else if (c == 101) begin
        START = 1'b0;
      end
      if (DONE === 1'b1) begin
        done_cnt++;
        if (first_done == 0) first_done = c;
      end
    end
    e = exp_attempt(24'hA055C3, -1);
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL ignore_done_count: got %0d expected 1", done_cnt); end
    checks++;
    if (first_done != TXN_CYC) begin errors++; $display("FAIL ignore_latency: got %0d expected %0d", first_done, TXN_CYC); end
    checks++;
    if (mon_log != e) begin errors++; $display("FAIL ignore_bus: got %s expected %s", mon_log, e); end
  endtask

  task automatic test_mid_reset();
    int cyc;
    string e;
    prep(-1, 0);
    start_txn(24'hA53C0F);
    // byte 1, bit 4 occupies slot 14: cycles 225..240 after acceptance
    repeat (229) @(posedge CLK);
    #1;
    checks++;
    if (ACK_LOG !== 3'b001) begin errors++; $display("FAIL midrst_pre_ack: got %b expected 001", ACK_LOG); end
    #2;
    RESET = 1'b1;
    #1;
    checks++;
    if (I2C_SCLK !== 1'b1 || sda_line !== 1'b1 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL midrst_bus: scl=%b sda=%b busy=%b expected 1/1/0", I2C_SCLK, sda_line, BUSY);
    end
    checks++;
    if (ACK_LOG !== 3'b000 || DONE !== 1'b0) begin
      errors++;
      $display("FAIL midrst_status: ack_log=%b done=%b expected 000/0", ACK_LOG, DONE);
    end
    @(negedge CLK);
    RESET = 1'b0;
    repeat (4) @(posedge CLK);
    prep(-1, 0);
    start_txn(24'h5AC3E7);
    wait_done(cyc);
    e = exp_attempt(24'h5AC3E7, -1);
    checks++;
    if (cyc != TXN_CYC) begin errors++; $display("FAIL midrst_latency: got %0d expected %0d", cyc, TXN_CYC); end
    checks++;
    if (mon_log != e) begin errors++; $display("FAIL midrst_bus_after: got %s expected %s", mon_log, e); end
    checks++;
    if (ACK_LOG !== 3'b111 || NACK_ERR !== 1'b0) begin
      errors++;
      $display("FAIL midrst_status_after: ack_log=%b nack_err=%b expected 111/0", ACK_LOG, NACK_ERR);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_addr_nack();
    test_retry_byte2();
    test_back_to_back();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
